// File: rtl/counter_pkg.sv
// Shared types for the bounded up/down counter.
package counter_pkg;

    // Overflow policy: clamp at the crossed bound, or jump to the opposite bound.
    typedef enum logic {
        CNT_SATURATE = 1'b0,
        CNT_WRAP     = 1'b1
    } counter_mode_e;

    localparam int COUNTER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count arithmetic: load clamp, bound repair, step with
// saturate/wrap policy, and the overflow/underflow/wrap events it produces.
module counter_next
    import counter_pkg::*;
#(
    parameter int            WIDTH_P = COUNTER_DEFAULT_WIDTH,
    parameter counter_mode_e MODE_P  = CNT_SATURATE
) (
    input  logic [WIDTH_P-1:0] count_i,
    input  logic               load_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic [WIDTH_P-1:0] step_i,
    input  logic [WIDTH_P-1:0] min_i,
    input  logic [WIDTH_P-1:0] max_i,
    output logic [WIDTH_P-1:0] next_o,
    output logic               ovf_o,
    output logic               unf_o,
    output logic               wrap_o
);

    // One extra bit keeps the carry of count+step and the sign of count-step.
    logic [WIDTH_P:0] sum_w;
    logic [WIDTH_P:0] diff_w;

    assign sum_w  = {1'b0, count_i} + {1'b0, step_i};
    assign diff_w = {1'b0, count_i} - {1'b0, step_i};

    // Priority: load, then out-of-range repair, then a single-direction step.
    always_comb begin
        next_o = count_i;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        wrap_o = 1'b0;
        if (load_i) begin
            if (data_i < min_i)      next_o = min_i;
            else if (data_i > max_i) next_o = max_i;
            else                     next_o = data_i;
        end else if (count_i < min_i) begin
            next_o = min_i;
        end else if (count_i > max_i) begin
            next_o = max_i;
        end else if ((up_i ^ down_i) && (step_i != '0)) begin
            if (up_i) begin
                if (sum_w > {1'b0, max_i}) begin
                    next_o = (MODE_P == CNT_WRAP) ? min_i : max_i;
                    ovf_o  = 1'b1;
                    wrap_o = 1'b1;
                end else begin
                    next_o = sum_w[WIDTH_P-1:0];
                end
            end else begin
                if ($signed(diff_w) < $signed({1'b0, min_i})) begin
                    next_o = (MODE_P == CNT_WRAP) ? max_i : min_i;
                    unf_o  = 1'b1;
                    wrap_o = 1'b1;
                end else begin
                    next_o = diff_w[WIDTH_P-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/counter_mode.sv
// Bounded up/down counter: holds the count, wrap pulse and sticky flags;
// next-value arithmetic lives in counter_next.
module counter_mode
    import counter_pkg::*;
#(
    parameter int                  WIDTH_P     = COUNTER_DEFAULT_WIDTH,
    parameter counter_mode_e       MODE_P      = CNT_SATURATE,
    parameter logic [WIDTH_P-1:0]  RESET_VAL_P = '0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic [WIDTH_P-1:0] step_i,
    input  logic [WIDTH_P-1:0] min_i,
    input  logic [WIDTH_P-1:0] max_i,
    input  logic               clear_flags_i,
    output logic [WIDTH_P-1:0] count_o,
    output logic               at_min_o,
    output logic               at_max_o,
    output logic               wrap_o,
    output logic               ovf_o,
    output logic               unf_o,
    output logic               cfg_err_o
);

    logic [WIDTH_P-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [WIDTH_P-1:0] next_cnt;
    logic               ev_ovf, ev_unf, ev_wrap;
    logic               cfg_err;
    logic               upd;

    // Inverted bounds freeze the whole counter, flags included.
    assign cfg_err = (min_i > max_i);
    assign upd     = en_i & ~cfg_err;

    counter_next #(
        .WIDTH_P (WIDTH_P),
        .MODE_P  (MODE_P)
    ) u_next (
        .count_i (count_q),
        .load_i  (load_i),
        .data_i  (data_i),
        .up_i    (up_i),
        .down_i  (down_i),
        .step_i  (step_i),
        .min_i   (min_i),
        .max_i   (max_i),
        .next_o  (next_cnt),
        .ovf_o   (ev_ovf),
        .unf_o   (ev_unf),
        .wrap_o  (ev_wrap)
    );

    // Next state: count/wrap only move on enabled cycles; a set event beats clear.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (upd) begin
            count_d = next_cnt;
            wrap_d  = ev_wrap;
        end
        if (!cfg_err) begin
            if (upd && ev_ovf)      ovf_d = 1'b1;
            else if (clear_flags_i) ovf_d = 1'b0;
            if (upd && ev_unf)      unf_d = 1'b1;
            else if (clear_flags_i) unf_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= RESET_VAL_P;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o   = count_q;
    assign at_min_o  = (count_q == min_i);
    assign at_max_o  = (count_q == max_i);
    assign wrap_o    = wrap_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;
    assign cfg_err_o = cfg_err;

endmodule

// File: tb/tb_counter_mode.sv
// Bench for counter_mode: a saturating instance (reset value 5) and a wrapping
// instance (reset value 0) share stimulus and are compared to a reference model.
module tb_counter_mode;
    import counter_pkg::*;

    logic       clk, rstn, en, load, up, down, clr;
    logic [7:0] data, step, mn, mx;

    logic [7:0] s_cnt, w_cnt;
    logic s_amin, s_amax, s_wrap, s_ovf, s_unf, s_cfg;
    logic w_amin, w_amax, w_wrap, w_ovf, w_unf, w_cfg;

    int total = 0;
    int bad   = 0;

    counter_mode #(.WIDTH_P(8), .MODE_P(CNT_SATURATE), .RESET_VAL_P(8'd5)) dut_sat (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .load_i(load), .data_i(data),
        .up_i(up), .down_i(down), .step_i(step), .min_i(mn), .max_i(mx),
        .clear_flags_i(clr), .count_o(s_cnt), .at_min_o(s_amin), .at_max_o(s_amax),
        .wrap_o(s_wrap), .ovf_o(s_ovf), .unf_o(s_unf), .cfg_err_o(s_cfg));

    counter_mode #(.WIDTH_P(8), .MODE_P(CNT_WRAP), .RESET_VAL_P(8'd0)) dut_wrap (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .load_i(load), .data_i(data),
        .up_i(up), .down_i(down), .step_i(step), .min_i(mn), .max_i(mx),
        .clear_flags_i(clr), .count_o(w_cnt), .at_min_o(w_amin), .at_max_o(w_amax),
        .wrap_o(w_wrap), .ovf_o(w_ovf), .unf_o(w_unf), .cfg_err_o(w_cfg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the counting rules.
    typedef struct packed { int cnt; bit w; bit o; bit u; } ref_t;

    function automatic ref_t ref_step(input bit wm, input int c, input bit e,
                                      input bit ld, input int d, input bit u_,
                                      input bit dn, input int st, input int lo, input int hi);
        ref_t r;
        r = '{cnt: c, w: 1'b0, o: 1'b0, u: 1'b0};
        if (!e || lo > hi) return r;
        if (ld)          r.cnt = (d < lo) ? lo : ((d > hi) ? hi : d);
        else if (c < lo) r.cnt = lo;
        else if (c > hi) r.cnt = hi;
        else if (u_ != dn && st != 0) begin
            if (u_) begin
                if (c + st > hi) begin r.cnt = wm ? lo : hi; r.o = 1'b1; r.w = 1'b1; end
                else r.cnt = c + st;
            end else begin
                if (c - st < lo) begin r.cnt = wm ? hi : lo; r.u = 1'b1; r.w = 1'b1; end
                else r.cnt = c - st;
            end
        end
        return r;
    endfunction

    int   m_cnt0, m_cnt1;
    bit   m_w0, m_w1, m_o0, m_o1, m_u0, m_u1;
    ref_t nr0, nr1;
    bit   m_cfg;

    assign m_cfg = (int'(mn) > int'(mx));
    assign nr0 = ref_step(1'b0, m_cnt0, en, load, int'(data), up, down, int'(step), int'(mn), int'(mx));
    assign nr1 = ref_step(1'b1, m_cnt1, en, load, int'(data), up, down, int'(step), int'(mn), int'(mx));

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt0 <= 5; m_cnt1 <= 0;
            m_w0 <= 0; m_w1 <= 0; m_o0 <= 0; m_o1 <= 0; m_u0 <= 0; m_u1 <= 0;
        end else begin
            m_cnt0 <= nr0.cnt; m_w0 <= nr0.w;
            m_cnt1 <= nr1.cnt; m_w1 <= nr1.w;
            if (!m_cfg) begin
                if (nr0.o) m_o0 <= 1; else if (clr) m_o0 <= 0;
                if (nr0.u) m_u0 <= 1; else if (clr) m_u0 <= 0;
                if (nr1.o) m_o1 <= 1; else if (clr) m_o1 <= 0;
                if (nr1.u) m_u1 <= 1; else if (clr) m_u1 <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; load = 0; up = 0; down = 0; clr = 0; data = 0; step = 0;
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs(); mn = 8'd10; mx = 8'd200;
        tick(); tick();
        total++;
        if (s_cnt !== 8'd5 || w_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_count sat=%0d wrap=%0d exp 5/0", s_cnt, w_cnt);
        end
        total++;
        if ({s_wrap, s_ovf, s_unf, w_wrap, w_ovf, w_unf} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {s_wrap, s_ovf, s_unf, w_wrap, w_ovf, w_unf});
        end
        rstn = 1;
    endtask

    task automatic test_load();
        en = 1; load = 1; data = 8'd250; tick();
        total++;
        if (s_cnt !== 8'd200 || w_cnt !== 8'd200 || s_amax !== 1'b1) begin
            bad++; $display("FAIL load_hi sat=%0d wrap=%0d at_max=%b exp 200/200/1", s_cnt, w_cnt, s_amax);
        end
        data = 8'd3; tick();
        total++;
        if (s_cnt !== 8'd10 || s_amin !== 1'b1 || {s_wrap, s_ovf, s_unf} !== 3'b0) begin
            bad++; $display("FAIL load_lo cnt=%0d at_min=%b flags=%b exp 10/1/000", s_cnt, s_amin, {s_wrap, s_ovf, s_unf});
        end
    endtask

    task automatic test_saturate();
        load = 1; data = 8'd195; tick();
        load = 0; up = 1; step = 8'd4; tick();
        total++;
        if (s_cnt !== 8'd199 || s_wrap !== 1'b0 || s_ovf !== 1'b0) begin
            bad++; $display("FAIL sat_up1 cnt=%0d wrap=%b ovf=%b exp 199/0/0", s_cnt, s_wrap, s_ovf);
        end
        tick();
        total++;
        if (s_cnt !== 8'd200 || s_wrap !== 1'b1 || s_ovf !== 1'b1) begin
            bad++; $display("FAIL sat_up2 cnt=%0d wrap=%b ovf=%b exp 200/1/1", s_cnt, s_wrap, s_ovf);
        end
        tick();
        total++;
        if (s_cnt !== 8'd200 || s_wrap !== 1'b1) begin
            bad++; $display("FAIL sat_up3 cnt=%0d wrap=%b exp 200/1", s_cnt, s_wrap);
        end
    endtask

    task automatic test_wrap();
        idle_inputs(); clr = 1; tick();
        total++;
        if ({w_ovf, w_unf, s_ovf, s_unf} !== 4'b0) begin
            bad++; $display("FAIL clear_no_en got=%b exp=0000", {w_ovf, w_unf, s_ovf, s_unf});
        end
        clr = 0; en = 1; load = 1; data = 8'd198; tick();
        load = 0; up = 1; step = 8'd5; tick();
        total++;
        if (w_cnt !== 8'd10 || w_ovf !== 1'b1 || w_wrap !== 1'b1) begin
            bad++; $display("FAIL wrap_up cnt=%0d ovf=%b wrap=%b exp 10/1/1", w_cnt, w_ovf, w_wrap);
        end
        up = 0; down = 1; step = 8'd1; tick();
        total++;
        if (w_cnt !== 8'd200 || w_unf !== 1'b1 || w_wrap !== 1'b1) begin
            bad++; $display("FAIL wrap_down cnt=%0d unf=%b wrap=%b exp 200/1/1", w_cnt, w_unf, w_wrap);
        end
        idle_inputs(); clr = 1; tick();
        total++;
        if ({w_ovf, w_unf, w_wrap} !== 3'b0) begin
            bad++; $display("FAIL wrap_clear got=%b exp=000", {w_ovf, w_unf, w_wrap});
        end
        clr = 0;
    endtask

    task automatic test_hold();
        en = 1; load = 1; data = 8'd150; tick();
        load = 0; up = 1; down = 1; step = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (s_cnt !== 8'd150 || w_cnt !== 8'd150 || s_wrap !== 1'b0) begin
                bad++; $display("FAIL hold_both i=%0d sat=%0d wrap_cnt=%0d wrap=%b exp 150/150/0", i, s_cnt, w_cnt, s_wrap);
            end
        end
        en = 0; down = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (s_cnt !== 8'd150 || w_cnt !== 8'd150 || w_wrap !== 1'b0) begin
                bad++; $display("FAIL hold_en i=%0d sat=%0d wrap_cnt=%0d wrap=%b exp 150/150/0", i, s_cnt, w_cnt, w_wrap);
            end
        end
        en = 1; up = 0; load = 1; data = 8'd200; tick();
        load = 0; up = 1; step = 8'd1; clr = 1; tick();
        total++;
        if (s_cnt !== 8'd200 || s_ovf !== 1'b1 || s_wrap !== 1'b1) begin
            bad++; $display("FAIL set_beats_clear cnt=%0d ovf=%b wrap=%b exp 200/1/1", s_cnt, s_ovf, s_wrap);
        end
        idle_inputs();
    endtask

    task automatic test_cfg_err();
        mn = 8'd50; mx = 8'd40; #1;
        total++;
        if (s_cfg !== 1'b1 || w_cfg !== 1'b1) begin
            bad++; $display("FAIL cfg_err got=%b%b exp=11", s_cfg, w_cfg);
        end
        en = 1; load = 1; data = 8'd45; tick();
        load = 0; up = 1; step = 8'd7; tick();
        total++;
        if (s_cnt !== 8'd200 || s_wrap !== 1'b0) begin
            bad++; $display("FAIL cfg_hold cnt=%0d wrap=%b exp 200/0", s_cnt, s_wrap);
        end
        rstn = 0; idle_inputs(); mn = 8'd10; mx = 8'd200;
        tick(); rstn = 1;
        total++;
        if (s_cnt !== 8'd5 || s_cfg !== 1'b0) begin
            bad++; $display("FAIL cfg_reset cnt=%0d cfg=%b exp 5/0", s_cnt, s_cfg);
        end
        en = 1; tick();
        total++;
        if (s_cnt !== 8'd10 || {s_wrap, s_ovf, s_unf} !== 3'b0) begin
            bad++; $display("FAIL clamp_up cnt=%0d flags=%b exp 10/000", s_cnt, {s_wrap, s_ovf, s_unf});
        end
    endtask

    task automatic test_async_reset();
        en = 1; up = 1; step = 8'd250; tick();
        total++;
        if (s_ovf !== 1'b1 || s_cnt !== 8'd200) begin
            bad++; $display("FAIL pre_reset ovf=%b cnt=%0d exp 1/200", s_ovf, s_cnt);
        end
        step = 8'd1; #2; rstn = 0; #1;
        total++;
        if (s_cnt !== 8'd5 || w_cnt !== 8'd0 ||
            {s_wrap, s_ovf, s_unf, w_wrap, w_ovf, w_unf} !== 6'b0) begin
            bad++; $display("FAIL async_reset sat=%0d wrap_cnt=%0d flags=%b exp 5/0/000000",
                            s_cnt, w_cnt, {s_wrap, s_ovf, s_unf, w_wrap, w_ovf, w_unf});
        end
        idle_inputs(); tick(); rstn = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 99) < 85);
            load = ($urandom_range(0, 99) < 10);
            up   = 1'($urandom);
            down = 1'($urandom);
            clr  = ($urandom_range(0, 99) < 10);
            data = 8'($urandom);
            step = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            if (i % 25 == 0) begin
                mn = 8'($urandom_range(0, 120));
                mx = 8'($urandom_range(100, 255));
                if ($urandom_range(0, 9) == 0) begin mn = 8'd150; mx = 8'd90; end
            end
            tick();
            total++;
            if (s_cnt !== 8'(m_cnt0) || w_cnt !== 8'(m_cnt1)) begin
                bad++; $display("FAIL rnd_count i=%0d sat=%0d/%0d wrap=%0d/%0d", i, s_cnt, m_cnt0, w_cnt, m_cnt1);
            end
            total++;
            if ({s_wrap, s_ovf, s_unf, s_amin, s_amax, s_cfg} !==
                {m_w0, m_o0, m_u0, (m_cnt0 == int'(mn)), (m_cnt0 == int'(mx)), m_cfg}) begin
                bad++; $display("FAIL rnd_sat_flags i=%0d got=%b exp=%b", i,
                    {s_wrap, s_ovf, s_unf, s_amin, s_amax, s_cfg},
                    {m_w0, m_o0, m_u0, (m_cnt0 == int'(mn)), (m_cnt0 == int'(mx)), m_cfg});
            end
            total++;
            if ({w_wrap, w_ovf, w_unf, w_amin, w_amax, w_cfg} !==
                {m_w1, m_o1, m_u1, (m_cnt1 == int'(mn)), (m_cnt1 == int'(mx)), m_cfg}) begin
                bad++; $display("FAIL rnd_wrap_flags i=%0d got=%b exp=%b", i,
                    {w_wrap, w_ovf, w_unf, w_amin, w_amax, w_cfg},
                    {m_w1, m_o1, m_u1, (m_cnt1 == int'(mn)), (m_cnt1 == int'(mx)), m_cfg});
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_saturate();
        test_wrap();
        test_hold();
        test_cfg_err();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_mode.md
COUNTER_MODE -- requirements
Module: counter_mode

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, count/data width in bits.
REQ-002 SHALL have parameter MODE_P, default CNT_SATURATE, overflow policy: CNT_SATURATE clamps at bound; CNT_WRAP jumps to opposite bound.
REQ-003 SHALL have parameter RESET_VAL_P, default 0, count value applied on reset.
REQ-004 SHALL have ports:
- clk_i  input  1  sole clock, rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- en_i  input  1  cycle enable for load and count.
- load_i  input  1  load data_i.
- data_i  input  WIDTH_P  load value.
- up_i  input  1  count up by step_i.
- down_i  input  1  count down by step_i.
- step_i  input  WIDTH_P  increment magnitude.
- min_i  input  WIDTH_P  lower bound, inclusive.
- max_i  input  WIDTH_P  upper bound, inclusive.
- clear_flags_i  input  1  clear sticky flags.
- count_o  output  WIDTH_P  registered count.
- at_min_o  output  1  count_o == min_i.
- at_max_o  output  1  count_o == max_i.
- wrap_o  output  1  one-cycle pulse, bound crossed on the previous edge.
- ovf_o  output  1  sticky overflow.
- unf_o  output  1  sticky underflow.
- cfg_err_o  output  1  min_i > max_i, combinational.

Function
REQ-005 SHALL update count_o only on rising clk_i with en_i=1; en_i=0 holds count_o and forces wrap_o=0 on the next edge.
REQ-006 SHALL apply priority load_i > (up_i xor down_i); up_i=down_i=1 or both 0 SHALL hold.
REQ-007 SHALL load data_i clamped into [min_i, max_i]; no flag or wrap pulse on load.
REQ-008 SHALL compute count+step and count-step in WIDTH_P+1 bits so no intermediate truncation occurs.
REQ-009 Up with count+step <= max_i SHALL give count+step; down with count-step >= min_i (signed compare) SHALL give count-step.
REQ-010 Up with count+step > max_i SHALL give max_i under CNT_SATURATE or min_i under CNT_WRAP, SHALL set ovf_o and pulse wrap_o.
REQ-011 Down with count-step < min_i SHALL give min_i under CNT_SATURATE or max_i under CNT_WRAP, SHALL set unf_o and pulse wrap_o.
REQ-012 Under CNT_SATURATE, up at count==max_i with step_i>0 SHALL hold max_i and still set ovf_o/pulse wrap_o (likewise down at min_i).
REQ-013 step_i=0 SHALL hold count with no flags.
REQ-014 If count_o lies outside [min_i, max_i] on an enabled non-load cycle, count SHALL clamp to the nearest bound, ignoring up_i/down_i, without flags.
REQ-015 While cfg_err_o=1, count_o SHALL hold regardless of load/up/down; flags hold.
REQ-016 clear_flags_i SHALL clear ovf_o/unf_o at the next edge independent of en_i; simultaneous set event SHALL win.
REQ-017 at_min_o/at_max_o SHALL be combinational compares of registered count_o to current min_i/max_i.

Reset
REQ-018 rstn_i=0 SHALL asynchronously force count_o=RESET_VAL_P, wrap_o=0, ovf_o=0, unf_o=0.
REQ-019 Reset mid-operation SHALL discard any pending load or step; first post-reset edge SHALL behave as normal enabled cycle.

Structure
REQ-020 Shared package counter_pkg SHALL define enum counter_mode_e {CNT_SATURATE, CNT_WRAP}.
REQ-021 Next-value arithmetic (REQ-007..014) SHALL be a combinational sub-module counter_next; counter_mode holds registers and flags.

Verification (WIDTH_P=8, min_i=10, max_i=200)
REQ-022 load 250 -> count_o=200, at_max_o=1; load 3 -> count_o=10, at_min_o=1, no flags.
REQ-023 CNT_SATURATE, count 195, step 4, up x2 -> 199 then 200 with ovf_o=1, wrap_o pulse; third up holds 200, wrap_o pulses again.
REQ-024 CNT_WRAP, count 198, step 5, up -> 10, ovf_o=1; down step 1 -> 200, unf_o=1; clear_flags_i -> both 0.
REQ-025 up_i=down_i=1 or en_i=0 for 3 cycles -> count_o unchanged, wrap_o=0; clear_flags_i with overflow same edge -> ovf_o=1.
REQ-026 min_i=50, max_i=40 -> cfg_err_o=1, load/up ignored; restore min_i=10 with count 5 (after reset RESET_VAL_P=5) -> count_o=10 next enabled edge.
REQ-027 Assert rstn_i mid-count between edges -> count_o=RESET_VAL_P immediately, all flags 0.
